// File: rtl/ws2812_chain_driver.sv
// ws2812_chain_driver: streams N_LEDS pixel words out of a pixel source onto a
// single WS2812-style one-wire line, MSB first, followed by a low latch period.
//
// Ports:
//   clk, rst_n   single clock, asynchronous active-low reset
//   start        frame request, only looked at while idle
//   busy         high from the cycle after start is taken until frame_done
//   pix_req      pixel request, pix_idx valid while high
//   pix_idx      index of the requested LED
//   pix_data     pixel word from the source (taken on pix_req & pix_valid)
//   pix_valid    pix_data qualifier
//   dout         serial line to the LED chain
//   underrun     (only with WS2812_UNDERRUN_ABORT_EN) sticky underrun flag
//   frame_done   one-cycle pulse on the last latch cycle
//
// Optional feature macro: WS2812_UNDERRUN_ABORT_EN
//   defined   : a missing next pixel aborts the frame into the latch period
//   undefined : a missing next pixel stalls the line low until it arrives
module ws2812_chain_driver #(
    parameter int unsigned N_LEDS   = 8,
    parameter int unsigned BPP      = 24,
    parameter int unsigned T0H_CYC  = 20,
    parameter int unsigned T1H_CYC  = 40,
    parameter int unsigned TBIT_CYC = 63,
    parameter int unsigned TRST_CYC = 2600,
    localparam int unsigned IDXW    = $clog2((N_LEDS > 2) ? N_LEDS : 2)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic            busy,
    output logic            pix_req,
    output logic [IDXW-1:0] pix_idx,
    input  logic [BPP-1:0]  pix_data,
    input  logic            pix_valid,
    output logic            dout,
`ifdef WS2812_UNDERRUN_ABORT_EN
    output logic            underrun,
`endif
    output logic            frame_done
);

    localparam int unsigned CW = $clog2(TBIT_CYC + 1);
    localparam int unsigned BW = $clog2(BPP + 1);
    localparam int unsigned LW = $clog2(TRST_CYC + 1);

    localparam logic [CW-1:0]   TBIT_LAST  = CW'(TBIT_CYC - 1);
    localparam logic [CW-1:0]   T0H        = CW'(T0H_CYC);
    localparam logic [CW-1:0]   T1H        = CW'(T1H_CYC);
    localparam logic [BW-1:0]   BIT_LAST   = BW'(BPP - 1);
    localparam logic [LW-1:0]   LATCH_LAST = LW'(TRST_CYC - 1);
    localparam logic [IDXW-1:0] PIX_LAST   = IDXW'(N_LEDS - 1);

    typedef enum logic [2:0] {IDLE, FETCH, BIT_HI, BIT_LO, LATCH} state_t;

    state_t          state;
    logic [BPP-1:0]  shift_q;
    logic [BPP-1:0]  hold_q;
    logic            hold_valid;
    logic            pre_arm;      // raise the prefetch request next cycle
    logic [CW-1:0]   cyc_cnt;      // cycle within the current bit
    logic [BW-1:0]   bit_cnt;      // bit within the current pixel
    logic [LW-1:0]   lat_cnt;
    logic [IDXW-1:0] pix_cur;      // pixel currently on the line

    logic            accept_c;
    logic [CW-1:0]   high_c;
    logic [CW-1:0]   cyc_nxt_c;
    logic            last_bit_c;
    logic            last_pix_c;
    logic            next_ok_c;
    logic [BPP-1:0]  next_word_c;

    // Bit timing and next-pixel selection helpers
    always_comb begin
        accept_c    = pix_req & pix_valid;
        high_c      = shift_q[BPP-1] ? T1H : T0H;
        cyc_nxt_c   = cyc_cnt + CW'(1);
        last_bit_c  = (bit_cnt == BIT_LAST);
        last_pix_c  = (pix_cur == PIX_LAST);
        // A word accepted on the very last bit cycle is used directly, no gap
        next_ok_c   = hold_valid | accept_c;
        next_word_c = hold_valid ? hold_q : pix_data;
    end

    // Frame FSM with registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            busy       <= 1'b0;
            pix_req    <= 1'b0;
            pix_idx    <= '0;
            dout       <= 1'b0;
            frame_done <= 1'b0;
            shift_q    <= '0;
            hold_q     <= '0;
            hold_valid <= 1'b0;
            pre_arm    <= 1'b0;
            cyc_cnt    <= '0;
            bit_cnt    <= '0;
            lat_cnt    <= '0;
            pix_cur    <= '0;
`ifdef WS2812_UNDERRUN_ABORT_EN
            underrun   <= 1'b0;
`endif
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    dout <= 1'b0;
                    if (start) begin
                        state      <= FETCH;
                        busy       <= 1'b1;
                        pix_req    <= 1'b1;
                        pix_idx    <= '0;
                        pix_cur    <= '0;
                        hold_valid <= 1'b0;
                        pre_arm    <= 1'b0;
`ifdef WS2812_UNDERRUN_ABORT_EN
                        underrun   <= 1'b0;
`endif
                    end
                end

                // Waiting for the first pixel, or for a late pixel after a stall
                FETCH: begin
                    dout <= 1'b0;
                    if (accept_c) begin
                        shift_q <= pix_data;
                        pix_req <= 1'b0;
                        pre_arm <= !last_pix_c;
                        cyc_cnt <= '0;
                        bit_cnt <= '0;
                        dout    <= 1'b1;
                        state   <= BIT_HI;
                    end
                end

                BIT_HI, BIT_LO: begin
                    if (pre_arm) begin
                        pix_req <= 1'b1;
                        pix_idx <= pix_cur + IDXW'(1);
                        pre_arm <= 1'b0;
                    end
                    if (accept_c) begin
                        hold_q     <= pix_data;
                        hold_valid <= 1'b1;
                        pix_req    <= 1'b0;
                    end

                    if (cyc_cnt != TBIT_LAST) begin
                        cyc_cnt <= cyc_nxt_c;
                        dout    <= (cyc_nxt_c < high_c);
                        state   <= (cyc_nxt_c < high_c) ? BIT_HI : BIT_LO;
                    end else if (!last_bit_c) begin
                        shift_q <= shift_q << 1;
                        bit_cnt <= bit_cnt + BW'(1);
                        cyc_cnt <= '0;
                        dout    <= 1'b1;
                        state   <= BIT_HI;
                    end else if (last_pix_c) begin
                        dout       <= 1'b0;
                        lat_cnt    <= '0;
                        frame_done <= (TRST_CYC == 1);
                        state      <= LATCH;
                    end else if (next_ok_c) begin
                        shift_q    <= next_word_c;
                        hold_valid <= 1'b0;
                        pix_req    <= 1'b0;
                        pix_cur    <= pix_cur + IDXW'(1);
                        pre_arm    <= ((pix_cur + IDXW'(1)) != PIX_LAST);
                        bit_cnt    <= '0;
                        cyc_cnt    <= '0;
                        dout       <= 1'b1;
                        state      <= BIT_HI;
                    end else begin
`ifdef WS2812_UNDERRUN_ABORT_EN
                        underrun   <= 1'b1;
                        pix_req    <= 1'b0;
                        dout       <= 1'b0;
                        lat_cnt    <= '0;
                        frame_done <= (TRST_CYC == 1);
                        state      <= LATCH;
`else
                        // Request for the next pixel stays up; FETCH picks it up
                        pix_cur <= pix_cur + IDXW'(1);
                        dout    <= 1'b0;
                        state   <= FETCH;
`endif
                    end
                end

                LATCH: begin
                    dout <= 1'b0;
                    if (lat_cnt == LATCH_LAST) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        lat_cnt    <= lat_cnt + LW'(1);
                        frame_done <= ((lat_cnt + LW'(1)) == LATCH_LAST);
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
